// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush/bubble control for the 5-stage pipe,
// with multi-cycle branch flush, memory-wait timeout and a stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WAIT_LIMIT   = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regWrite,
  input  logic                  ex_regSelect,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  bubble_ex,
  output logic                  stall_ex,
  output logic [1:0]            hz_state,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int unsigned WAIT_BITS = $clog2(WAIT_LIMIT + 1);
  localparam int unsigned WAIT_W    = (WAIT_BITS > 8) ? WAIT_BITS : 8;
  localparam int unsigned FLUSH_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(WAIT_LIMIT);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;

  logic load_use;
  logic mem_stall;
  logic do_hold;
  logic do_flush;
  logic do_lu;

  always_comb begin
    load_use  = ex_regWrite & ex_regSelect & (ex_rd != '0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    mem_stall = mem_req & ~mem_ready;
    do_hold   = 1'b0;
    do_flush  = 1'b0;
    do_lu     = 1'b0;
    if (rst) begin
      unique case (state)
        S_RUN: begin
          if (mem_stall)            do_hold  = 1'b1;
          else if (ex_branch_taken) do_flush = 1'b1;
          else if (load_use)        do_lu    = 1'b1;
        end
        S_FLUSH: begin
          if (mem_stall) do_hold  = 1'b1;
          else           do_flush = 1'b1;
        end
        S_MEM_WAIT: begin
          if (!mem_ready)           do_hold  = 1'b1;
          else if (ex_branch_taken) do_flush = 1'b1;
          else if (load_use)        do_lu    = 1'b1;
        end
        S_ERROR: do_hold = 1'b1;
        default: ;
      endcase
    end
    stall_if  = do_hold | do_lu;
    stall_id  = do_hold | do_lu;
    stall_ex  = do_hold;
    flush_id  = do_flush;
    bubble_ex = do_flush | do_lu;
  end

  assign hz_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
      timeout_err <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_if && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      unique case (state)
        S_RUN: begin
          if (mem_stall) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
            if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
              state     <= S_FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end
        end
        S_FLUSH: begin
          // A memory stall pauses the flush; flush_cnt holds, wait_cnt times it out.
          if (mem_stall) begin
            if (wait_cnt == WAIT_MAX) begin
              state       <= S_ERROR;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt  <= '0;
            flush_cnt <= flush_cnt - FLUSH_W'(1);
            if (flush_cnt == FLUSH_W'(1))
              state <= S_RUN;
          end
        end
        S_MEM_WAIT: begin
          if (!mem_ready) begin
            if (wait_cnt == WAIT_MAX) begin
              state       <= S_ERROR;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
            if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
              state     <= S_FLUSH;
              flush_cnt <= FLUSH_INIT;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_ERROR: ;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RAW = 5;
  localparam int unsigned CW  = 4;

  localparam logic [4:0] C_NONE = 5'b00000;  // {stall_if,stall_id,flush_id,bubble_ex,stall_ex}
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_FL   = 5'b00110;
  localparam logic [4:0] C_ST   = 5'b11001;

  logic           clk = 1'b0;
  logic           rst;
  logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
  logic           id_uses_rs1, id_uses_rs2;
  logic           ex_regWrite, ex_regSelect, ex_branch_taken;
  logic           mem_req, mem_ready;
  logic           stall_if, stall_id, flush_id, bubble_ex, stall_ex;
  logic [1:0]     hz_state;
  logic           timeout_err;
  logic [CW-1:0]  stall_count;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (RAW),
    .FLUSH_CYCLES(2),
    .WAIT_LIMIT  (4),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_regWrite    (ex_regWrite),
    .ex_regSelect   (ex_regSelect),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .bubble_ex      (bubble_ex),
    .stall_ex       (stall_ex),
    .hz_state       (hz_state),
    .timeout_err    (timeout_err),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] a;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall_if, stall_id, flush_id, bubble_ex, stall_ex, hz_state, timeout_err, stall_count};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got ctrl=%b st=%0d to=%b cnt=%0d, required ctrl=%b st=%0d to=%b cnt=%0d",
                 n, a[11:7], a[6:5], a[4], a[3:0], e[11:7], e[6:5], e[4], e[3:0]);
      end
    end
  end

  task automatic step(input string nm, input logic [4:0] c, input logic [1:0] s,
                      input logic t, input int unsigned k);
    exp_q.push_back({c, s, t, CW'(k)});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_regWrite = 1'b0; ex_regSelect = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [RAW-1:0] r);
    ex_regWrite = 1'b1; ex_regSelect = 1'b1; ex_rd = r;
    id_rs1 = r; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step("rst", C_NONE, 2'd0, 1'b0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish, required finish before 20000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step("reset", C_NONE, 2'd0, 1'b0, 0);
    mem_req = 1'b1; ex_branch_taken = 1'b1; set_lu(5);
    step("reset_forced", C_NONE, 2'd0, 1'b0, 0);
    idle(); rst = 1'b1;
    step("idle", C_NONE, 2'd0, 1'b0, 0);

    // Load-use detection
    set_lu(5);
    step("lu_rs1", C_LU, 2'd0, 1'b0, 0);
    idle();
    step("lu_clear", C_NONE, 2'd0, 1'b0, 1);
    set_lu(0);
    step("lu_rd0", C_NONE, 2'd0, 1'b0, 1);
    idle();
    ex_regWrite = 1'b1; ex_regSelect = 1'b1; ex_rd = 7;
    id_rs2 = 7; id_uses_rs2 = 1'b1; id_rs1 = 5; id_uses_rs1 = 1'b1;
    step("lu_rs2", C_LU, 2'd0, 1'b0, 1);
    id_uses_rs2 = 1'b0;
    step("lu_unused", C_NONE, 2'd0, 1'b0, 2);
    id_uses_rs2 = 1'b1; ex_regSelect = 1'b0;
    step("lu_notload", C_NONE, 2'd0, 1'b0, 2);

    // Taken branch, alone and with simultaneous load-use
    idle(); ex_branch_taken = 1'b1;
    step("br_run", C_FL, 2'd0, 1'b0, 2);
    ex_branch_taken = 1'b0;
    step("br_flush", C_FL, 2'd1, 1'b0, 2);
    step("br_done", C_NONE, 2'd0, 1'b0, 2);
    ex_branch_taken = 1'b1; set_lu(5);
    step("br_lu_run", C_FL, 2'd0, 1'b0, 2);
    step("br_lu_flush", C_FL, 2'd1, 1'b0, 2);
    idle();
    step("br_lu_done", C_NONE, 2'd0, 1'b0, 2);

    // Memory wait, release, and ready-cycle servicing of branch / load-use
    do_reset();
    mem_req = 1'b1;
    step("mw_run", C_ST, 2'd0, 1'b0, 0);
    step("mw_1", C_ST, 2'd2, 1'b0, 1);
    step("mw_2", C_ST, 2'd2, 1'b0, 2);
    step("mw_3", C_ST, 2'd2, 1'b0, 3);
    mem_ready = 1'b1;
    step("mw_ready", C_NONE, 2'd2, 1'b0, 4);
    idle();
    step("mw_done", C_NONE, 2'd0, 1'b0, 4);
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    step("mwbr_run", C_ST, 2'd0, 1'b0, 4);
    step("mwbr_wait", C_ST, 2'd2, 1'b0, 5);
    mem_ready = 1'b1;
    step("mwbr_ready", C_FL, 2'd2, 1'b0, 6);
    idle();
    step("mwbr_flush", C_FL, 2'd1, 1'b0, 6);
    step("mwbr_done", C_NONE, 2'd0, 1'b0, 6);
    mem_req = 1'b1;
    step("mwlu_run", C_ST, 2'd0, 1'b0, 6);
    mem_ready = 1'b1; set_lu(9);
    step("mwlu_ready", C_LU, 2'd2, 1'b0, 7);
    idle();
    step("mwlu_done", C_NONE, 2'd0, 1'b0, 8);

    // Timeout at WAIT_LIMIT=4, sticky error, counter saturation, reset exit
    do_reset();
    mem_req = 1'b1;
    step("to_run", C_ST, 2'd0, 1'b0, 0);
    for (int k = 1; k <= 4; k++) step("to_wait", C_ST, 2'd2, 1'b0, k);
    step("to_error", C_ST, 2'd3, 1'b1, 5);
    mem_req = 1'b0; mem_ready = 1'b1;
    step("err_sticky", C_ST, 2'd3, 1'b1, 6);
    for (int k = 7; k <= 15; k++) step("err_count", C_ST, 2'd3, 1'b1, k);
    step("err_sat", C_ST, 2'd3, 1'b1, 15);
    step("err_sat", C_ST, 2'd3, 1'b1, 15);
    rst = 1'b0;
    step("err_reset", C_NONE, 2'd0, 1'b0, 0);
    rst = 1'b1; idle();
    step("err_cleared", C_NONE, 2'd0, 1'b0, 0);

    // Memory stall during FLUSH pauses the remaining bubble
    ex_branch_taken = 1'b1;
    step("fm_br", C_FL, 2'd0, 1'b0, 0);
    ex_branch_taken = 1'b0; mem_req = 1'b1;
    step("fm_stall1", C_ST, 2'd1, 1'b0, 0);
    step("fm_stall2", C_ST, 2'd1, 1'b0, 1);
    mem_ready = 1'b1;
    step("fm_ready", C_FL, 2'd1, 1'b0, 2);
    idle();
    step("fm_done", C_NONE, 2'd0, 1'b0, 2);

    // Asynchronous reset mid memory wait
    mem_req = 1'b1;
    step("ar_run", C_ST, 2'd0, 1'b0, 2);
    step("ar_wait", C_ST, 2'd2, 1'b0, 3);
    rst = 1'b0;
    step("ar_reset", C_NONE, 2'd0, 1'b0, 0);
    rst = 1'b1;
    step("ar_restart", C_ST, 2'd0, 1'b0, 0);
    step("ar_w1", C_ST, 2'd2, 1'b0, 1);
    step("ar_w2", C_ST, 2'd2, 1'b0, 2);
    mem_ready = 1'b1;
    step("ar_ready", C_NONE, 2'd2, 1'b0, 3);
    idle();
    step("ar_done", C_NONE, 2'd0, 1'b0, 3);

    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
